// File: rtl/timer_bank_pkg.sv
// Shared types and helpers for the timer bank: channel mode encoding and
// the derivation of the channel-select width.
package timer_bank_pkg;

  typedef enum logic [1:0] {
    MODE_TOGGLE  = 2'b00,
    MODE_TICK    = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_e;

  // A single-channel bank still needs a 1-bit select field.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One programmable divider/timer channel: counter, target, mode and enable
// registers with a load port that takes priority over counting.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 ld,
  input  logic [BIT_WIDTH-1:0] ld_target,
  input  logic [1:0]           ld_mode,
  input  logic                 ld_enable,
  output logic                 clk_out,
  output logic                 tick,
  output logic                 active,
  output logic [BIT_WIDTH-1:0] cnt
);

  logic [BIT_WIDTH-1:0] cnt_r, cnt_s;
  logic [BIT_WIDTH-1:0] target_r, target_s;
  mode_e                mode_r, mode_s;
  logic                 enable_r, enable_s;
  logic                 clk_out_r, clk_out_s;
  logic                 tick_r, tick_s;
  logic                 active_r, active_s;

  // Next-state: load, then hold, then count, then terminal-count action.
  always_comb begin
    cnt_s     = cnt_r;
    target_s  = target_r;
    mode_s    = mode_r;
    enable_s  = enable_r;
    clk_out_s = clk_out_r;
    tick_s    = 1'b0;
    if (ld) begin
      target_s  = ld_target;
      mode_s    = mode_e'(ld_mode);
      enable_s  = ld_enable;
      cnt_s     = {BIT_WIDTH{1'b0}};
      clk_out_s = 1'b0;
    end else if (!enable_r || (mode_r == MODE_HOLD)) begin
      cnt_s = cnt_r;
    end else if (cnt_r < target_r) begin
      cnt_s = cnt_r + {{(BIT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_s  = {BIT_WIDTH{1'b0}};
      tick_s = 1'b1;
      case (mode_r)
        MODE_TOGGLE:  clk_out_s = ~clk_out_r;
        MODE_TICK:    clk_out_s = 1'b0;
        MODE_ONESHOT: begin
          enable_s  = 1'b0;
          clk_out_s = 1'b0;
        end
        default:      clk_out_s = clk_out_r;
      endcase
    end
    active_s = enable_s && (mode_s != MODE_HOLD);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      cnt_r     <= {BIT_WIDTH{1'b0}};
      target_r  <= {BIT_WIDTH{1'b0}};
      mode_r    <= MODE_TOGGLE;
      enable_r  <= 1'b0;
      clk_out_r <= 1'b0;
      tick_r    <= 1'b0;
      active_r  <= 1'b0;
    end else begin
      cnt_r     <= cnt_s;
      target_r  <= target_s;
      mode_r    <= mode_s;
      enable_r  <= enable_s;
      clk_out_r <= clk_out_s;
      tick_r    <= tick_s;
      active_r  <= active_s;
    end
  end

  assign clk_out = clk_out_r;
  assign tick    = tick_r;
  assign active  = active_r;
  assign cnt     = cnt_r;

endmodule

// File: rtl/timer_bank.sv
// N-channel programmable clock divider / timer bank. A single write port
// reprograms one channel per cycle; out-of-range channel indices are ignored.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter  int BIT_WIDTH = 32,
  parameter  int N_CH      = 4,
  localparam int CH_W      = ch_width(N_CH)
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [CH_W-1:0]           wr_ch,
  input  logic [BIT_WIDTH-1:0]      wr_target,
  input  logic [1:0]                wr_mode,
  input  logic                      wr_enable,
  output logic [N_CH-1:0]           clk_out,
  output logic [N_CH-1:0]           tick,
  output logic [N_CH-1:0]           active,
  output logic [N_CH*BIT_WIDTH-1:0] cnt_out
);

  logic [N_CH-1:0] ld_s;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    // Indices at or above N_CH match no channel, so such writes are dropped.
    assign ld_s[i] = wr_en && (wr_ch == CH_W'(i));

    timer_channel #(
      .BIT_WIDTH(BIT_WIDTH)
    ) u_channel (
      .clk_in   (clk_in),
      .reset    (reset),
      .ld       (ld_s[i]),
      .ld_target(wr_target),
      .ld_mode  (wr_mode),
      .ld_enable(wr_enable),
      .clk_out  (clk_out[i]),
      .tick     (tick[i]),
      .active   (active[i]),
      .cnt      (cnt_out[i*BIT_WIDTH +: BIT_WIDTH])
    );
  end

endmodule
